fetch_ctrl: RTL

//  Fetch sequencer for the IF stage. Owns the PC register and issues requests to instruction ROM over a
//  req/gnt/rvalid handshake. Drops responses made stale by a branch/jump redirect.

---
 rtl/fetch_ctrl_pkg.sv | 18 +
 rtl/fetch_ctrl_buf.sv | 38 +++
 rtl/fetch_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the IF-stage fetch sequencer.
//   XLEN_DEF     : default datapath/address width
//   RESET_PC_DEF : default first fetch address after reset
//   INST_NOP     : bubble instruction (addi x0,x0,0)
//   fetch_state_e: fetch FSM states (2-bit encoding)
package fetch_ctrl_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_KILL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_buf.sv
// One-entry {pc, inst, valid} buffer between the ROM response and IF/ID.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : drop the entry (wins over load)
//   load            : capture load_pc/load_inst, mark valid
//   consume         : entry taken downstream, clear valid unless reloaded
//   pc, inst, valid : stored entry
module fetch_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic         consume,
  input  logic [W-1:0] load_pc,
  input  logic [W-1:0] load_inst,
  output logic [W-1:0] pc,
  output logic [W-1:0] inst,
  output logic         valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      inst  <= load_inst;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer. Owns the PC, issues single-outstanding ROM
// requests (req/gnt/rvalid), drops responses made stale by a redirect and
// buffers one instruction for the IF/ID register.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   stall_i               : pipeline stall; if_stall_o mirrors it
//   redirect_i/_pc_i      : branch/jump redirect (highest priority)
//   rom_req_o/rom_addr_o  : fetch request and word-aligned address
//   rom_gnt_i             : ROM accepts the request
//   rom_rvalid_i/_rdata_i : ROM response
//   pc_o, inst_o, valid_o : fetched instruction to IF/ID (NOP when invalid)
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            rom_req_o,
  output logic [XLEN-1:0] rom_addr_o,
  input  logic            rom_gnt_i,
  input  logic            rom_rvalid_i,
  input  logic [XLEN-1:0] rom_rdata_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic            valid_o,
  output logic            if_stall_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, req_pc_q;
  logic [XLEN-1:0] buf_pc, buf_inst;
  logic            buf_valid;
  logic            consume, issue, load;

  // Only the word address of the target matters.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  assign consume = buf_valid & ~stall_i;

  // Request only when the buffer will have room for the response; this keeps
  // a landing response from ever meeting a full buffer, even under stall.
  assign rom_req_o  = ~rst_i & (state_q == FETCH_REQ) & (~buf_valid | consume);
  assign rom_addr_o = pc_q;
  assign issue      = rom_req_o & rom_gnt_i;

  // Responses arriving in KILL, or together with a redirect, are stale.
  assign load = (state_q == FETCH_WAIT) & rom_rvalid_i & ~redirect_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_REQ:  if (issue) state_d = redirect_i ? FETCH_KILL : FETCH_WAIT;
      FETCH_WAIT: begin
        if (rom_rvalid_i)    state_d = FETCH_REQ;
        else if (redirect_i) state_d = FETCH_KILL;
      end
      FETCH_KILL: if (rom_rvalid_i) state_d = FETCH_REQ;
      default:    state_d = FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= FETCH_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_i)  pc_q <= {redirect_pc_i[XLEN-1:2], 2'b00};
      else if (issue)  pc_q <= pc_q + XLEN'(4);
      if (issue)       req_pc_q <= pc_q;
    end
  end

  fetch_buf #(.W(XLEN)) u_buf (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (redirect_i),
    .load      (load),
    .consume   (consume),
    .load_pc   (req_pc_q),
    .load_inst (rom_rdata_i),
    .pc        (buf_pc),
    .inst      (buf_inst),
    .valid     (buf_valid)
  );

  assign valid_o    = buf_valid;
  assign pc_o       = buf_pc;
  assign inst_o     = buf_valid ? buf_inst : XLEN'(INST_NOP);
  assign if_stall_o = stall_i;

endmodule
